// File: rtl/axi4_split_pkg.sv
// Shared helpers for the wide-to-narrow AXI4 write converter: W split state
// encoding, ratio/log2 constants, narrow size encoding and burst length scaling.
package axi4_split_pkg;

  typedef enum logic {
    W_EMPTY = 1'b0,
    W_SPLIT = 1'b1
  } w_state_e;

  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ratio_of(input int wide_bits, input int narrow_bits);
    return wide_bits / narrow_bits;
  endfunction

  // AXI awsize encoding for a beat of the given byte count.
  function automatic logic [2:0] size_enc(input int bytes);
    return 3'(log2_ceil(bytes));
  endfunction

  // (len+1)*2^lg - 1, i.e. len with lg one-bits appended below it.
  function automatic logic [31:0] len_scale(input logic [31:0] len, input int lg);
    return (len << lg) | ((32'd1 << lg) - 32'd1);
  endfunction

endpackage

// File: rtl/width_split_verb.sv
// W-channel splitter: holds one wide beat and emits it as RATIO narrow beats,
// least-significant lane first.
module width_split_verb
  import axi4_split_pkg::*;
#(
  parameter int ISIZE = 128,
  parameter int OSIZE = 32
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [ISIZE-1:0]   s_wdata,
  input  logic [ISIZE/8-1:0] s_wstrb,
  input  logic               s_wlast,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [OSIZE-1:0]   m_wdata,
  output logic [OSIZE/8-1:0] m_wstrb,
  output logic               m_wlast,
  output logic               m_wvalid,
  input  logic               m_wready
);

  localparam int RATIO = ratio_of(ISIZE, OSIZE);
  localparam int LW    = log2_ceil(RATIO);
  localparam int IB    = ISIZE / 8;
  localparam int OB    = OSIZE / 8;
  localparam logic [LW-1:0] LAST_IDX = LW'(RATIO - 1);

  w_state_e          state_q;
  logic [LW-1:0]     idx_q;
  logic [ISIZE-1:0]  data_q;
  logic [IB-1:0]     strb_q;
  logic              last_q;

  logic [OSIZE-1:0]  lane_data [RATIO];
  logic [OB-1:0]     lane_strb [RATIO];
  logic              on_last_lane;
  logic              wide_accept;
  logic              narrow_accept;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lane_data[gi] = data_q[gi*OSIZE +: OSIZE];
    assign lane_strb[gi] = strb_q[gi*OB +: OB];
  end

  assign on_last_lane  = (idx_q == LAST_IDX);
  assign m_wvalid      = (state_q == W_SPLIT);
  // A new wide beat may enter while the last lane of the current one leaves.
  assign s_wready      = (state_q == W_EMPTY) || (m_wready && on_last_lane);
  assign wide_accept   = s_wvalid && s_wready;
  assign narrow_accept = m_wvalid && m_wready;

  assign m_wdata = lane_data[idx_q];
  assign m_wstrb = lane_strb[idx_q];
  assign m_wlast = m_wvalid && last_q && on_last_lane;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= W_EMPTY;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else if (wide_accept) begin
      state_q <= W_SPLIT;
      idx_q   <= '0;
      data_q  <= s_wdata;
      strb_q  <= s_wstrb;
      last_q  <= s_wlast;
    end else if (narrow_accept) begin
      if (on_last_lane) begin
        state_q <= W_EMPTY;
        idx_q   <= '0;
      end else begin
        idx_q   <= idx_q + LW'(1);
      end
    end
  end

endmodule

// File: rtl/axi4_data_split_a1.sv
// Downsizing AXI4 write-path converter: re-encodes AW bursts for the narrow
// port and splits every wide W beat into RATIO narrow beats.
module axi4_data_split_a1
  import axi4_split_pkg::*;
#(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int ILSIZE = 8,
  parameter int OLSIZE = 10,
  parameter int ISIZE  = 128,
  parameter int OSIZE  = 32
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [IDSIZE-1:0]  s_awid,
  input  logic [ASIZE-1:0]   s_awaddr,
  input  logic [ILSIZE-1:0]  s_awlen,
  input  logic [2:0]         s_awsize,
  input  logic [1:0]         s_awburst,
  input  logic               s_awvalid,
  output logic               s_awready,
  output logic [IDSIZE-1:0]  m_awid,
  output logic [ASIZE-1:0]   m_awaddr,
  output logic [OLSIZE-1:0]  m_awlen,
  output logic [2:0]         m_awsize,
  output logic [1:0]         m_awburst,
  output logic               m_awvalid,
  input  logic               m_awready,
  input  logic [ISIZE-1:0]   s_wdata,
  input  logic [ISIZE/8-1:0] s_wstrb,
  input  logic               s_wlast,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [OSIZE-1:0]   m_wdata,
  output logic [OSIZE/8-1:0] m_wstrb,
  output logic               m_wlast,
  output logic               m_wvalid,
  input  logic               m_wready
);

  localparam int RATIO = ratio_of(ISIZE, OSIZE);
  localparam int LOG2R = log2_ceil(RATIO);
  localparam logic [2:0] NARROW_SIZE = size_enc(OSIZE / 8);

  if (ISIZE % OSIZE != 0) begin : g_chk_div
    $fatal(1, "ISIZE must be a multiple of OSIZE");
  end
  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_chk_ratio
    $fatal(1, "ISIZE/OSIZE must be a power of two >= 2");
  end
  if (OLSIZE < ILSIZE + LOG2R) begin : g_chk_len
    $fatal(1, "OLSIZE too narrow for scaled burst length");
  end

  logic [IDSIZE-1:0] m_awid_q;
  logic [ASIZE-1:0]  m_awaddr_q;
  logic [OLSIZE-1:0] m_awlen_q;
  logic [OLSIZE-1:0] m_awlen_d;
  logic [2:0]        m_awsize_q;
  logic [1:0]        m_awburst_q;
  logic              m_awvalid_q;
  logic              aw_load;

  // Only full-width input beats are supported, so the incoming size is irrelevant.
  logic unused_awsize;
  assign unused_awsize = ^s_awsize;

  assign m_awlen_d = OLSIZE'(len_scale(32'(s_awlen), LOG2R));
  assign s_awready = !m_awvalid_q || m_awready;
  assign aw_load   = s_awvalid && s_awready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      m_awvalid_q <= 1'b0;
      m_awid_q    <= '0;
      m_awaddr_q  <= '0;
      m_awlen_q   <= '0;
      m_awsize_q  <= '0;
      m_awburst_q <= '0;
    end else if (aw_load) begin
      m_awvalid_q <= 1'b1;
      m_awid_q    <= s_awid;
      m_awaddr_q  <= s_awaddr;
      m_awlen_q   <= m_awlen_d;
      m_awsize_q  <= NARROW_SIZE;
      m_awburst_q <= s_awburst;
    end else if (m_awready) begin
      m_awvalid_q <= 1'b0;
    end
  end

  assign m_awid    = m_awid_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awlen   = m_awlen_q;
  assign m_awsize  = m_awsize_q;
  assign m_awburst = m_awburst_q;
  assign m_awvalid = m_awvalid_q;

  width_split_verb #(
    .ISIZE (ISIZE),
    .OSIZE (OSIZE)
  ) u_split (
    .clock    (clock),
    .rst      (rst),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wlast  (s_wlast),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_wlast  (m_wlast),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready)
  );

endmodule

// File: tb/tb_axi4_data_split_a1.sv
// Self-checking bench: directed steps plus randomized traffic, scored against a
// queue-based model of the expected narrow AW and W streams.
module tb_axi4_data_split_a1;

  localparam int IDSIZE = 4;
  localparam int ASIZE  = 32;
  localparam int ILSIZE = 8;
  localparam int OLSIZE = 10;
  localparam int ISIZE  = 128;
  localparam int OSIZE  = 32;
  localparam int RATIO  = ISIZE / OSIZE;
  localparam int OB     = OSIZE / 8;

  logic               clock;
  logic               rst;
  logic [IDSIZE-1:0]  s_awid;
  logic [ASIZE-1:0]   s_awaddr;
  logic [ILSIZE-1:0]  s_awlen;
  logic [2:0]         s_awsize;
  logic [1:0]         s_awburst;
  logic               s_awvalid;
  logic               s_awready;
  logic [IDSIZE-1:0]  m_awid;
  logic [ASIZE-1:0]   m_awaddr;
  logic [OLSIZE-1:0]  m_awlen;
  logic [2:0]         m_awsize;
  logic [1:0]         m_awburst;
  logic               m_awvalid;
  logic               m_awready;
  logic [ISIZE-1:0]   s_wdata;
  logic [ISIZE/8-1:0] s_wstrb;
  logic               s_wlast;
  logic               s_wvalid;
  logic               s_wready;
  logic [OSIZE-1:0]   m_wdata;
  logic [OSIZE/8-1:0] m_wstrb;
  logic               m_wlast;
  logic               m_wvalid;
  logic               m_wready;

  axi4_data_split_a1 #(
    .IDSIZE(IDSIZE), .ASIZE(ASIZE), .ILSIZE(ILSIZE),
    .OLSIZE(OLSIZE), .ISIZE(ISIZE), .OSIZE(OSIZE)
  ) dut (
    .clock(clock), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef logic [OSIZE+OB:0] wbeat_t;                       // {data, strb, last}
  typedef logic [IDSIZE+ASIZE+OLSIZE+4:0] awbeat_t;         // {id, addr, len, size, burst}

  wbeat_t  exp_w[$];
  awbeat_t exp_aw[$];
  int      hs_cyc[$];
  logic    w_stall = 1'b0;
  logic    aw_stall = 1'b0;
  wbeat_t  w_prev;
  awbeat_t aw_prev;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: each accepted wide beat becomes RATIO narrow beats, lane k = bits
  // [k*OSIZE +: OSIZE]; each accepted AW becomes len'=(len+1)*RATIO-1, size=log2(OSIZE/8).
  always @(negedge clock) begin
    if (rst) begin
      exp_w.delete();
      exp_aw.delete();
      w_stall  = 1'b0;
      aw_stall = 1'b0;
    end else begin
      if (w_stall) chk("w_stable", {m_wvalid, m_wdata, m_wstrb, m_wlast}, {1'b1, w_prev});
      if (m_wvalid && m_wready) begin
        if (exp_w.size() == 0) chk("w_unexpected_beat", 256'(exp_w.size()), 256'd1);
        else chk("w_beat", {m_wdata, m_wstrb, m_wlast}, exp_w.pop_front());
        hs_cyc.push_back(cyc);
      end
      w_stall = m_wvalid && !m_wready;
      w_prev  = {m_wdata, m_wstrb, m_wlast};
      if (s_wvalid && s_wready) begin
        for (int k = 0; k < RATIO; k++) begin
          exp_w.push_back({OSIZE'(s_wdata >> (k * OSIZE)), OB'(s_wstrb >> (k * OB)),
                           (s_wlast && k == RATIO - 1)});
        end
      end

      if (aw_stall)
        chk("aw_stable", {m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}, {1'b1, aw_prev});
      if (m_awvalid && m_awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 256'(exp_aw.size()), 256'd1);
        else chk("aw_beat", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}, exp_aw.pop_front());
      end
      aw_stall = m_awvalid && !m_awready;
      aw_prev  = {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst};
      if (s_awvalid && s_awready)
        exp_aw.push_back({s_awid, s_awaddr, OLSIZE'((int'(s_awlen) + 1) * RATIO - 1), 3'd2, s_awburst});
    end
  end

  task automatic send_wide(input logic [ISIZE-1:0] d, input logic [ISIZE/8-1:0] s, input logic l);
    int t;
    s_wdata = d; s_wstrb = s; s_wlast = l; s_wvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clock);
      if (s_wready || t >= 200) break;
      t++;
    end
    chk("s_wready_timeout", 256'(t < 200), 256'd1);
    @(posedge clock); #1;
    s_wvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] a,
                         input logic [ILSIZE-1:0] len, input logic [1:0] b);
    int t;
    s_awid = id; s_awaddr = a; s_awlen = len; s_awsize = 3'd4; s_awburst = b; s_awvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clock);
      if (s_awready || t >= 200) break;
      t++;
    end
    chk("s_awready_timeout", 256'(t < 200), 256'd1);
    @(posedge clock); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    m_wready = 1'b1; m_awready = 1'b1;
    t = 0;
    while ((exp_w.size() != 0 || exp_aw.size() != 0 || m_wvalid || m_awvalid) && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    chk(tag, 256'(t < 300), 256'd1);
  endtask

  initial begin
    logic [ISIZE-1:0] d;
    int n0;
    int t;
    rst = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    m_awready = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; m_wready = 1'b0;
    #1;
    chk("rst_m_awvalid", 256'(m_awvalid), 256'd0);
    chk("rst_m_wvalid", 256'(m_wvalid), 256'd0);
    chk("rst_m_wlast", 256'(m_wlast), 256'd0);
    chk("rst_m_wdata", 256'(m_wdata), 256'd0);
    chk("rst_m_awlen", 256'(m_awlen), 256'd0);
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    chk("rst_s_awready", 256'(s_awready), 256'd1);
    chk("rst_s_wready", 256'(s_wready), 256'd1);

    // AW re-encode, one cycle latency
    m_awready = 1'b1;
    send_aw(4'h5, 32'h100, 8'd3, 2'd1);
    chk("aw_valid", 256'(m_awvalid), 256'd1);
    chk("aw_addr", 256'(m_awaddr), 256'h100);
    chk("aw_len", 256'(m_awlen), 256'd15);
    chk("aw_size", 256'(m_awsize), 256'd2);
    chk("aw_id_burst", 256'({m_awid, m_awburst}), 256'({4'h5, 2'd1}));
    @(posedge clock); #1;
    chk("aw_valid_drop", 256'(m_awvalid), 256'd0);

    // AW len=255 with a 3-cycle downstream stall
    m_awready = 1'b0;
    send_aw(4'hA, 32'hDEAD_BEEF, 8'd255, 2'd2);
    s_awid = 4'h3; s_awaddr = 32'h40; s_awlen = 8'd7; s_awburst = 2'd1; s_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("aw_stall_ready", 256'(s_awready), 256'd0);
      chk("aw_len_max", 256'({m_awvalid, m_awlen}), 256'({1'b1, 10'd1023}));
    end
    @(posedge clock); #1;
    m_awready = 1'b1;
    @(negedge clock);
    chk("aw_ready_resume", 256'(s_awready), 256'd1);
    @(posedge clock); #1;
    s_awvalid = 1'b0;
    drain("aw_drain");

    // W split of one wide beat
    m_wready = 1'b1;
    send_wide(128'h44444444_33333333_22222222_11111111, 16'hF0FF, 1'b1);
    chk("w_lane0", 256'({m_wvalid, m_wdata, m_wstrb, m_wlast}), 256'({1'b1, 32'h11111111, 4'hF, 1'b0}));
    @(posedge clock); #1;
    chk("w_lane1", 256'({m_wvalid, m_wdata, m_wstrb, m_wlast}), 256'({1'b1, 32'h22222222, 4'hF, 1'b0}));
    @(posedge clock); #1;
    chk("w_lane2", 256'({m_wvalid, m_wdata, m_wstrb, m_wlast}), 256'({1'b1, 32'h33333333, 4'h0, 1'b0}));
    @(posedge clock); #1;
    chk("w_lane3", 256'({m_wvalid, m_wdata, m_wstrb, m_wlast}), 256'({1'b1, 32'h44444444, 4'hF, 1'b1}));
    @(posedge clock); #1;
    chk("w_idle", 256'(m_wvalid), 256'd0);

    // Two back-to-back wide beats: 8 narrow beats in 8 consecutive cycles
    n0 = hs_cyc.size();
    send_wide({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0);
    send_wide({$urandom, $urandom, $urandom, $urandom}, 16'h0F3C, 1'b1);
    t = 0;
    while (hs_cyc.size() < n0 + 8 && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    chk("b2b_count", 256'(hs_cyc.size() >= n0 + 8), 256'd1);
    if (hs_cyc.size() >= n0 + 8) chk("b2b_span", 256'(hs_cyc[n0 + 7] - hs_cyc[n0]), 256'd7);
    drain("b2b_drain");

    // Alternating m_wready: stalled payload must hold, nothing lost or duplicated
    m_wready = 1'b0;
    fork
      begin
        send_wide({$urandom, $urandom, $urandom, $urandom}, 16'hA5C3, 1'b0);
        send_wide({$urandom, $urandom, $urandom, $urandom}, 16'h1234, 1'b1);
      end
      begin
        for (int i = 0; i < 24; i++) begin
          m_wready = ~m_wready;
          @(posedge clock); #1;
        end
      end
    join
    drain("toggle_drain");

    // Reset after the 2nd narrow beat, then a fresh wide beat
    m_wready = 1'b1;
    send_wide(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wvalid", 256'({m_wvalid, m_wlast}), 256'd0);
    chk("rst_mid_wdata", 256'(m_wdata), 256'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    d = 128'h88888888_77777777_66666666_55555555;
    send_wide(d, 16'h00FF, 1'b1);
    chk("post_rst_lane0", 256'({m_wvalid, m_wdata, m_wstrb}), 256'({1'b1, 32'h55555555, 4'hF}));
    drain("rst_drain");

    // Randomized traffic on both channels with random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          send_wide({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'($urandom));
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          send_aw(4'($urandom), $urandom, 8'($urandom), 2'($urandom));
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          m_wready  = 1'($urandom);
          m_awready = 1'($urandom);
          @(posedge clock); #1;
        end
      end
    join
    drain("rand_drain");
    chk("final_queues", 256'(exp_w.size() + exp_aw.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
